seg_scan_ctrl: RTL
==================

# seg_scan_ctrl

Multiplexed scan controller that time-shares one external BCD seven-segment decoder across `DIGITS` common-enable digits. It latches a packed BCD word and presents one nibble at a time on `digit_out`, which drives the decoder's `data` input. At the same time it drives the active-low digit enables `sel` in step with the nibble. A guard interval between digit slots prevents ghosting. Optional leading-zero suppression and per-digit blanking are provided. Frame updates happen only at frame boundaries, so a displayed frame never mixes old and new data.

## Interface
- `DIGITS`, 4: number of digits, range 2–8.
- `REFRESH_DIV`, 50000: clock cycles per digit slot, minimum 2.
- `GUARD_CYC`, 2: cycles at the end of each slot with all digits off. Range 0 to `REFRESH_DIV`-1.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  scan enable. When low, the display is dark and the scanner is parked.
- `load`  in  1  capture `data_in` into the shadow register.
- `data_in`  in  4*DIGITS  packed BCD; nibble i is digit i, digit 0 is least significant.
- `blank_mask`  in  DIGITS  bit i=1 forces digit i dark.
- `lz_en`  in  1  enable leading-zero suppression.
- `digit_out`  out  4  BCD nibble to the decoder. `BLANK_CODE` (4'hF) when dark.
- `sel`  out  DIGITS  active-low one-hot digit enable. All ones when dark.
- `frame_tick`  out  1  one-cycle pulse at the start of each frame.

## Operation
- Reset values: `state`=IDLE, `idx`=0, `cnt`=0, `shadow`=0, `active`=0, `sel`=all ones, `digit_out`=4'hF, `frame_tick`=0.
- States:
  - IDLE: all digits off.
  - SCAN: `sel[idx]`=0; `digit_out` = effective nibble of digit `idx`.
  - GUARD: `sel` all ones; `digit_out`=4'hF.
- IDLE→SCAN when `en`=1. Entry sets `idx`=0 and `cnt`=0, copies `shadow` to `active`, and pulses `frame_tick`.
- Slot counter `cnt` runs 0..`REFRESH_DIV`-1:
  - SCAN while `cnt` < `REFRESH_DIV`-`GUARD_CYC`, GUARD for the remainder.
  - With `GUARD_CYC`=0, GUARD is never entered.
- At the end of a slot (`cnt`=`REFRESH_DIV`-1), `cnt` returns to 0 and `idx` increments modulo `DIGITS`.
- Wrap from `DIGITS`-1 to 0 is a frame boundary: `active` ← `shadow`, and `frame_tick`=1 for one cycle.
- `load`=1 sets `shadow` ← `data_in` on that edge.
- `load`=1 on a frame-boundary edge sets `active` ← `data_in` directly, bypassing shadow, and also updates `shadow`.
- Effective nibble of digit i is 4'hF if any of the following holds:
  - `blank_mask[i]`=1;
  - `lz_en`=1, i>0, and `active` nibbles i..`DIGITS`-1 are all 0.
  - Otherwise it is the `active` nibble i.
  - Digit 0 is never zero-suppressed.
  - Non-BCD nibbles (10–15) pass through unchanged; the decoder renders them dark.
- `blank_mask` and `lz_en` are sampled live every cycle, not frame-aligned.
- `en`=0 in any state → IDLE on the next edge, with `idx`=0, `cnt`=0, and outputs dark. `shadow` and `active` are retained.
- `rst` mid-scan takes priority over everything, including `en` and `load`. Next edge gives the reset values.

## Timing
- `sel`, `digit_out` and `frame_tick` are registers with no combinational path from inputs.
- `en` rising, sampled at edge N:
  - at edge N+1, `sel[0]`=0 and `frame_tick`=1;
  - first digit is lit for `REFRESH_DIV`-`GUARD_CYC` cycles, then dark for `GUARD_CYC` cycles.
- Frame period is `DIGITS`*`REFRESH_DIV` cycles. `frame_tick` is spaced exactly that far apart while `en`=1.
- `load` to visible: data appears at the next frame boundary edge, at most one frame period later. `load` exactly on the boundary edge gives 1-cycle latency.
- Enable change:
  - `sel` never has two zeros simultaneously;
  - `sel`[i] and `digit_out` change on the same edge.
- `blank_mask`/`lz_en` change: visible 1 cycle later.
- Counter width is $clog2(`REFRESH_DIV`); index width is $clog2(`DIGITS`). Both are unsigned with no overflow.

## Structure
- Shared package `seg_pkg`:
  - `BLANK_CODE`=4'hF;
  - `scan_state_t` enum {IDLE, SCAN, GUARD};
  - function `lz_blank(active, i)`.
- Sub-module `scan_tick_gen` is the slot counter. It outputs `slot_end` (at `cnt`=`REFRESH_DIV`-1) and `guard` (`cnt` ≥ `REFRESH_DIV`-`GUARD_CYC`), and takes `clk`, `rst`, `clr`.
- Top level holds the FSM, index, shadow/active registers, nibble mux and blanking logic.

## Test plan
All scenarios use `DIGITS`=4, `REFRESH_DIV`=8, `GUARD_CYC`=2.
1. Reset, then `en`=1 with preloaded 16'h1234 → `sel` sequence 1110, 1101, 1011, 0111. `digit_out` 4, 3, 2, 1, each for 6 cycles, then 1111/F for 2 cycles. `frame_tick` every 32 cycles.
2. `load` 16'h0567 mid-frame → current frame still shows 1234; next frame shows 7, 6, 5, 0.
3. `lz_en`=1 with 16'h0007 → digits 3..1 show F, digit 0 shows 7. With 16'h0000, only digit 0 shows 0.
4. `load` on the frame-boundary edge with 16'h9999 → digit 0 shows 9 in that frame. `blank_mask`=4'b0100 → digit 2 shows F with `sel[2]` still low.
5. `en`=0 mid-slot of digit 2 → next cycle `sel`=1111 and `digit_out`=F. Re-enable → restarts at digit 0 with `frame_tick`.
6. `rst` asserted together with `load`/`en` during SCAN → next cycle reset values hold. `shadow`=0 and `load` is ignored.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared types, constants and helpers for the seven-segment scan
// controller.
//   BLANK_CODE   - nibble sent to the external decoder for a dark digit
//   scan_state_t - scanner FSM states
//   lz_blank()   - leading-zero test for one digit of the displayed word
package seg_pkg;

    localparam logic [3:0] BLANK_CODE = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        GUARD
    } scan_state_t;

    // True when digit i is above digit 0 and it and every digit above it are
    // zero. The word is zero-extended to 8 digits, so the extra upper nibbles
    // never stop a suppression.
    function automatic logic lz_blank(input logic [31:0] act, input int i);
        logic zero;
        zero = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k >= i && act[k*4 +: 4] != 4'h0) zero = 1'b0;
        end
        return (i > 0) && zero;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen: slot counter for the digit scanner. It counts
// 0..REFRESH_DIV-1 and then wraps.
//   clk, rst    - clock and synchronous active-high reset
//   clr         - hold the counter at 0 (scanner parked)
//   slot_end    - counter is at REFRESH_DIV-1, the last cycle of a slot
//   guard       - counter is inside the guard tail of the slot
//   guard_enter - the next count is the first guard cycle of the slot
module scan_tick_gen #(
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD_CYC   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic slot_end,
    output logic guard,
    output logic guard_enter
);

    localparam int CW       = $clog2(REFRESH_DIV);
    localparam int SCAN_LEN = REFRESH_DIV - GUARD_CYC;

    logic [CW-1:0] cnt;

    // The compares are done in int. With GUARD_CYC=0, SCAN_LEN equals
    // REFRESH_DIV, and that value may not fit in CW bits.
    assign slot_end    = (cnt == CW'(REFRESH_DIV - 1));
    assign guard       = (GUARD_CYC > 0) && (int'(cnt) >= SCAN_LEN);
    assign guard_enter = (GUARD_CYC > 0) && (int'(cnt) == SCAN_LEN - 1);

    always_ff @(posedge clk) begin
        if (rst || clr)    cnt <= '0;
        else if (slot_end) cnt <= '0;
        else               cnt <= cnt + CW'(1);
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed scan controller. It time-shares one BCD
// seven-segment decoder across DIGITS common-enable digits.
//   clk, rst   - clock and synchronous active-high reset
//   en         - scan enable; when low the display is dark and the scanner parks
//   load       - capture data_in into the shadow word
//   data_in    - packed BCD, nibble i is digit i
//   blank_mask - per-digit force-dark, sampled every cycle
//   lz_en      - leading-zero suppression, sampled every cycle
//   digit_out  - nibble for the decoder, BLANK_CODE when dark
//   sel        - active-low one-hot digit enable, all ones when dark
//   frame_tick - one-cycle pulse on the first cycle of each frame
// All outputs are registered. They are computed from the next-state values,
// so they change on the same edge as the state they describe.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int REFRESH_DIV = 50000,
    parameter int GUARD_CYC   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data_in,
    input  logic [DIGITS-1:0]     blank_mask,
    input  logic                  lz_en,
    output logic [3:0]            digit_out,
    output logic [DIGITS-1:0]     sel,
    output logic                  frame_tick
);

    localparam int IW = $clog2(DIGITS);

    scan_state_t         state, state_n;
    logic [IW-1:0]       idx, idx_n;
    logic [4*DIGITS-1:0] shadow, active, active_n;
    logic                tick_n;
    logic                slot_end, guard, guard_enter, clr;
    logic [3:0]          nib_eff;

    // The counter runs only while the scanner is active. It is held at 0 in
    // IDLE, so the first slot after entry starts from cnt=0.
    assign clr = !en || (state == IDLE);

    scan_tick_gen #(
        .REFRESH_DIV (REFRESH_DIV),
        .GUARD_CYC   (GUARD_CYC)
    ) u_tick (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .slot_end    (slot_end),
        .guard       (guard),
        .guard_enter (guard_enter)
    );

    // Next-state logic. At a frame boundary (scan entry or a wrap from the
    // last digit), the shadow word is latched into active. A load on that
    // same edge bypasses the shadow.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        active_n = active;
        tick_n   = 1'b0;
        if (!en) begin
            state_n = IDLE;
            idx_n   = '0;
        end else if (state == IDLE) begin
            state_n  = SCAN;
            idx_n    = '0;
            active_n = load ? data_in : shadow;
            tick_n   = 1'b1;
        end else if (slot_end) begin
            state_n = SCAN;
            if (idx == IW'(DIGITS - 1)) begin
                idx_n    = '0;
                active_n = load ? data_in : shadow;
                tick_n   = 1'b1;
            end else begin
                idx_n = idx + IW'(1);
            end
        end else if (guard || guard_enter) begin
            state_n = GUARD;
        end else begin
            state_n = SCAN;
        end
    end

    // Effective nibble of the digit that is lit next. It uses the live blank
    // controls and the word that will be active after this edge.
    always_comb begin
        nib_eff = active_n[int'(idx_n)*4 +: 4];
        if (blank_mask[idx_n] || (lz_en && lz_blank(32'(active_n), int'(idx_n))))
            nib_eff = BLANK_CODE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            shadow     <= '0;
            active     <= '0;
            sel        <= '1;
            digit_out  <= BLANK_CODE;
            frame_tick <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            active     <= active_n;
            frame_tick <= tick_n;
            if (load) shadow <= data_in;
            if (state_n == SCAN) begin
                sel       <= ~(DIGITS'(1) << idx_n);
                digit_out <= nib_eff;
            end else begin
                sel       <= '1;
                digit_out <= BLANK_CODE;
            end
        end
    end

endmodule
